spi_bus_arbiter: RTL and testbench
==================================

// Module: spi_bus_arbiter
// PURPOSE
//  Shares one SPI master between the inertial interface (req 0) and the A2D interface (req 1).
//  Each requester posts a 16-bit command with a one-cycle wrt pulse; the arbiter buffers it (depth 1 per requester).
//  Inertial has fixed priority, with an anti-starvation cap for A2D.
//  Per transaction: issues the command, waits for spi_done, returns rd_data and done to the owner, then holds an inter-frame gap.
// PARAMETERS
//  GAP_CYC    4      idle clocks between spi_done and the next spi_wrt (SS_n recovery)
//  MAX_INERT  3      consecutive inertial grants allowed while an A2D request is pending
//  TMO_CYC    4096   max clocks in BUSY before the transaction is aborted
// PORTS
//  clk         in   1   system clock; single clock domain
//  rst         in   1   synchronous, active-high reset
//  inert_wrt   in   1   one-cycle pulse: post inert_cmd
//  inert_cmd   in   16  inertial SPI command word
//  inert_done  out  1   one-cycle pulse: inertial transaction finished
//  inert_rd    out  16  read data for inertial; valid with inert_done, held until next update
//  a2d_wrt     in   1   one-cycle pulse: post a2d_cmd
//  a2d_cmd     in   16  A2D SPI command word
//  a2d_done    out  1   one-cycle pulse: A2D transaction finished
//  a2d_rd      out  16  read data for A2D; valid with a2d_done
//  spi_wrt     out  1   one-cycle pulse to shared SPI master: start a transaction
//  spi_cmd     out  16  command to SPI master; stable from spi_wrt until spi_done
//  spi_done    in   1   one-cycle pulse from SPI master: transaction complete
//  spi_rd      in   16  SPI master read data; valid with spi_done
//  owner       out  1   0 = inertial, 1 = A2D; current/last grantee
//  busy        out  1   high in every state except IDLE
//  ovf_err     out  1   sticky: wrt arrived while that requester's slot was full
//  tmo_err     out  1   sticky: BUSY timeout occurred
// BEHAVIOUR
//  Reset: all outputs 0, slots empty, streak=0, state IDLE. Applies at any time, including mid-transaction.
//  Slot: wrt at edge k stores cmd and sets pend (visible cycle k+1).
//   - wrt with pend set and slot not issued that cycle -> cmd dropped, ovf_err=1.
//   - wrt in the same cycle the slot is issued -> new cmd stored, pend stays 1, no error.
//  FSM IDLE->BUSY->GAP->IDLE; every output is registered.
//  IDLE: if any pend -> select, spi_wrt=1 for 1 cycle, latch spi_cmd/owner, clear that pend, go BUSY.
//   - spi_wrt appears exactly 2 clocks after wrt when arbiter is idle with nothing pending.
//  Select: a2d if (a2d_pend & !inert_pend) | (a2d_pend & streak==MAX_INERT); else inert.
//  streak: +1 on inertial grant while a2d_pend=1 (saturates); cleared on A2D grant.
//  BUSY: on spi_done -> next cycle owner's done=1 and owner's rd=spi_rd; enter GAP with gap_cnt=0.
//   - The non-owner's done/rd are unchanged.
//   - spi_done outside BUSY is ignored.
//  BUSY timeout: tmo_cnt reaches TMO_CYC-1 without spi_done -> owner's done=1 with rd=16'hFFFF, tmo_err=1, go GAP.
//  GAP: counts GAP_CYC clocks, then IDLE. A pend present on the final GAP cycle issues on the IDLE cycle after it.
//  Requests posted during BUSY/GAP are buffered and never lost (slot not full).
//  Counters size to $clog2(param+1) bits; no wrap (saturate or cleared).
// STRUCTURE
//  segway_pkg: arb_state_t enum {IDLE,BUSY,GAP}; localparams OWN_INERT=1'b0, OWN_A2D=1'b1; BAD_RD=16'hFFFF.
//  Sub-module arb_req_slot (cmd reg + pend + ovf logic), instantiated twice.
//  Top-level integration is separate; this block contains FSM, select, streak, gap and timeout counters only.
// TESTING
//  1. Idle, inert_wrt cmd=16'hA2xx -> spi_wrt 2 clks later, spi_cmd=16'hA2xx, owner=0; spi_done rd=16'h1234 -> inert_done next clk, inert_rd=16'h1234, a2d_done=0.
//  2. inert_wrt and a2d_wrt same cycle -> inertial issued first; A2D spi_wrt exactly GAP_CYC+1 clks after the inertial done pulse.
//  3. a2d_pend held while inertial reposts every transaction -> grants I,I,I,A (MAX_INERT=3), then streak=0.
//  4. Second a2d_wrt while a2d slot full and not issuing -> ovf_err=1, first cmd issued unchanged; rst -> ovf_err=0.
//  5. spi_done withheld -> done at TMO_CYC, rd=16'hFFFF, tmo_err=1; stray spi_done in GAP ignored.
//  6. rst asserted mid-BUSY -> next clk all outputs 0, state IDLE; spi_done arriving after reset produces no done pulse.

Source files
------------

// File: rtl/segway_pkg.sv
// Shared types and constants for the SPI bus arbiter.
// Holds the FSM encoding, owner codes and the timeout read value.
package segway_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } arb_state_t;

    localparam logic        OWN_INERT = 1'b0;
    localparam logic        OWN_A2D   = 1'b1;
    localparam logic [15:0] BAD_RD    = 16'hFFFF;

    // A2D wins when inertial is idle, or when inertial has used up its streak
    function automatic logic pick_a2d(
        input logic inert_pend,
        input logic a2d_pend,
        input logic streak_full
    );
        return a2d_pend & (~inert_pend | streak_full);
    endfunction

endpackage

// File: rtl/arb_req_slot.sv
// One-deep command buffer for a single SPI requester.
// A post into a full slot is dropped unless the slot drains that same cycle.
module arb_req_slot
    import segway_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_wrt,
    input  logic [15:0] i_cmd,
    input  logic        i_issue,
    output logic        o_pend,
    output logic [15:0] o_cmd,
    output logic        o_ovf
);

    logic        r_pend;
    logic [15:0] r_cmd;
    logic        w_accept;

    assign w_accept = i_wrt & (~r_pend | i_issue);
    assign o_ovf    = i_wrt & r_pend & ~i_issue;
    assign o_pend   = r_pend;
    assign o_cmd    = r_cmd;

    // Capture accepted posts; an issue without a refill empties the slot
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pend <= 1'b0;
            r_cmd  <= '0;
        end else if (w_accept) begin
            r_pend <= 1'b1;
            r_cmd  <= i_cmd;
        end else if (i_issue) begin
            r_pend <= 1'b0;
        end
    end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Shares one SPI master between the inertial and A2D requesters.
// Fixed inertial priority with a streak cap, inter-frame gap and busy timeout.
module spi_bus_arbiter
    import segway_pkg::*;
#(
    parameter int GAP_CYC   = 4,
    parameter int MAX_INERT = 3,
    parameter int TMO_CYC   = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inert_wrt,
    input  logic [15:0] inert_cmd,
    output logic        inert_done,
    output logic [15:0] inert_rd,
    input  logic        a2d_wrt,
    input  logic [15:0] a2d_cmd,
    output logic        a2d_done,
    output logic [15:0] a2d_rd,
    output logic        spi_wrt,
    output logic [15:0] spi_cmd,
    input  logic        spi_done,
    input  logic [15:0] spi_rd,
    output logic        owner,
    output logic        busy,
    output logic        ovf_err,
    output logic        tmo_err
);

    localparam int GW = $clog2(GAP_CYC + 1);
    localparam int SW = $clog2(MAX_INERT + 1);
    localparam int TW = $clog2(TMO_CYC + 1);

    arb_state_t  r_state, w_state_n;
    logic [GW-1:0] r_gap_cnt, w_gap_n;
    logic [SW-1:0] r_streak, w_streak_n;
    logic [TW-1:0] r_tmo_cnt, w_tmo_n;
    logic        r_owner, w_owner_n;
    logic        r_spi_wrt, w_spi_wrt_n;
    logic [15:0] r_spi_cmd, w_spi_cmd_n;
    logic        r_i_done, w_i_done_n;
    logic [15:0] r_i_rd, w_i_rd_n;
    logic        r_a_done, w_a_done_n;
    logic [15:0] r_a_rd, w_a_rd_n;
    logic        r_busy, w_busy_n;
    logic        r_ovf_err, w_ovf_err_n;
    logic        r_tmo_err, w_tmo_err_n;

    logic        w_i_pend, w_a_pend;
    logic [15:0] w_i_cmd, w_a_cmd;
    logic        w_i_ovf, w_a_ovf;
    logic        w_issue, w_pick_a2d;
    logic        w_end_ok, w_end_tmo, w_gap_end;
    logic [15:0] w_rd;

    assign w_issue    = (r_state == IDLE) & (w_i_pend | w_a_pend);
    assign w_pick_a2d = pick_a2d(w_i_pend, w_a_pend,
                                 r_streak == SW'(MAX_INERT));
    assign w_end_ok   = (r_state == BUSY) & spi_done;
    assign w_end_tmo  = (r_state == BUSY) & ~spi_done &
                        (r_tmo_cnt == TW'(TMO_CYC - 1));
    assign w_gap_end  = (r_state == GAP) &
                        (r_gap_cnt == GW'(GAP_CYC - 1));
    assign w_rd       = w_end_ok ? spi_rd : BAD_RD;

    arb_req_slot u_inert_slot (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_wrt   (inert_wrt),
        .i_cmd   (inert_cmd),
        .i_issue (w_issue & ~w_pick_a2d),
        .o_pend  (w_i_pend),
        .o_cmd   (w_i_cmd),
        .o_ovf   (w_i_ovf)
    );

    arb_req_slot u_a2d_slot (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_wrt   (a2d_wrt),
        .i_cmd   (a2d_cmd),
        .i_issue (w_issue & w_pick_a2d),
        .o_pend  (w_a_pend),
        .o_cmd   (w_a_cmd),
        .o_ovf   (w_a_ovf)
    );

    // State, counters and every output are held in registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_gap_cnt <= '0;
            r_streak  <= '0;
            r_tmo_cnt <= '0;
            r_owner   <= OWN_INERT;
            r_spi_wrt <= 1'b0;
            r_spi_cmd <= '0;
            r_i_done  <= 1'b0;
            r_i_rd    <= '0;
            r_a_done  <= 1'b0;
            r_a_rd    <= '0;
            r_busy    <= 1'b0;
            r_ovf_err <= 1'b0;
            r_tmo_err <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_gap_cnt <= w_gap_n;
            r_streak  <= w_streak_n;
            r_tmo_cnt <= w_tmo_n;
            r_owner   <= w_owner_n;
            r_spi_wrt <= w_spi_wrt_n;
            r_spi_cmd <= w_spi_cmd_n;
            r_i_done  <= w_i_done_n;
            r_i_rd    <= w_i_rd_n;
            r_a_done  <= w_a_done_n;
            r_a_rd    <= w_a_rd_n;
            r_busy    <= w_busy_n;
            r_ovf_err <= w_ovf_err_n;
            r_tmo_err <= w_tmo_err_n;
        end
    end

    // Transaction sequencing: issue, wait for completion, then recover
    always_comb begin
        w_state_n = r_state;
        unique case (r_state)
            IDLE:    if (w_issue) w_state_n = BUSY;
            BUSY:    if (w_end_ok | w_end_tmo) w_state_n = GAP;
            GAP:     if (w_gap_end) w_state_n = IDLE;
            default: w_state_n = IDLE;
        endcase
    end

    // Next values for outputs, streak, gap and timeout counters
    always_comb begin
        w_spi_wrt_n = 1'b0;
        w_spi_cmd_n = r_spi_cmd;
        w_owner_n   = r_owner;
        w_i_done_n  = 1'b0;
        w_i_rd_n    = r_i_rd;
        w_a_done_n  = 1'b0;
        w_a_rd_n    = r_a_rd;
        w_streak_n  = r_streak;
        w_gap_n     = r_gap_cnt;
        w_tmo_n     = r_tmo_cnt;
        w_tmo_err_n = r_tmo_err;
        w_ovf_err_n = r_ovf_err | w_i_ovf | w_a_ovf;
        w_busy_n    = (w_state_n != IDLE);
        unique case (r_state)
            IDLE: begin
                if (w_issue) begin
                    w_spi_wrt_n = 1'b1;
                    w_tmo_n     = '0;
                    if (w_pick_a2d) begin
                        w_spi_cmd_n = w_a_cmd;
                        w_owner_n   = OWN_A2D;
                        w_streak_n  = '0;
                    end else begin
                        w_spi_cmd_n = w_i_cmd;
                        w_owner_n   = OWN_INERT;
                        if (w_a_pend && r_streak != SW'(MAX_INERT))
                            w_streak_n = r_streak + SW'(1);
                    end
                end
            end
            BUSY: begin
                if (w_end_ok | w_end_tmo) begin
                    w_gap_n     = '0;
                    w_tmo_err_n = r_tmo_err | w_end_tmo;
                    if (r_owner == OWN_A2D) begin
                        w_a_done_n = 1'b1;
                        w_a_rd_n   = w_rd;
                    end else begin
                        w_i_done_n = 1'b1;
                        w_i_rd_n   = w_rd;
                    end
                end else begin
                    w_tmo_n = r_tmo_cnt + TW'(1);
                end
            end
            GAP: begin
                if (!w_gap_end) w_gap_n = r_gap_cnt + GW'(1);
            end
            default: ;
        endcase
    end

    assign spi_wrt    = r_spi_wrt;
    assign spi_cmd    = r_spi_cmd;
    assign owner      = r_owner;
    assign inert_done = r_i_done;
    assign inert_rd   = r_i_rd;
    assign a2d_done   = r_a_done;
    assign a2d_rd     = r_a_rd;
    assign busy       = r_busy;
    assign ovf_err    = r_ovf_err;
    assign tmo_err    = r_tmo_err;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Self-checking bench for spi_bus_arbiter.
// Cycle table, directed corner sequences and a randomized transaction model.
module tb_spi_bus_arbiter;

    localparam int GAP  = 4;
    localparam int MAXI = 3;
    localparam int TMO  = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inert_wrt = 1'b0, a2d_wrt = 1'b0, spi_done = 1'b0;
    logic [15:0] inert_cmd = '0, a2d_cmd = '0, spi_rd = '0;
    logic        inert_done, a2d_done, spi_wrt, owner, busy;
    logic        ovf_err, tmo_err;
    logic [15:0] inert_rd, a2d_rd, spi_cmd;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    spi_bus_arbiter #(
        .GAP_CYC   (GAP),
        .MAX_INERT (MAXI),
        .TMO_CYC   (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .inert_wrt  (inert_wrt),
        .inert_cmd  (inert_cmd),
        .inert_done (inert_done),
        .inert_rd   (inert_rd),
        .a2d_wrt    (a2d_wrt),
        .a2d_cmd    (a2d_cmd),
        .a2d_done   (a2d_done),
        .a2d_rd     (a2d_rd),
        .spi_wrt    (spi_wrt),
        .spi_cmd    (spi_cmd),
        .spi_done   (spi_done),
        .spi_rd     (spi_rd),
        .owner      (owner),
        .busy       (busy),
        .ovf_err    (ovf_err),
        .tmo_err    (tmo_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iw;
        logic [15:0] ic;
        logic        aw;
        logic [15:0] ac;
        logic        sd;
        logic [15:0] sr;
        logic        e_wrt;
        logic [15:0] e_cmd;
        logic        e_own;
        logic        e_busy;
        logic        e_idone;
        logic [15:0] e_ird;
        logic        e_adone;
        logic [15:0] e_ard;
    } vec_t;

    vec_t tbl[17];

    // model state for the randomized phase
    bit          m_has[2];
    logic [15:0] m_cmd[2];
    int          m_edge[2];
    int          m_streak;
    int          last_done;
    bit          sp_active;
    int          sp_wait;
    int          sp_own;
    logic [15:0] sp_data;
    logic [15:0] sp_cmd;
    bit          exp_done;
    int          exp_own;
    logic [15:0] exp_data;
    int          grants;

    task automatic tick();
        @(negedge clk);
        cyc++;
        inert_wrt = 1'b0;
        a2d_wrt   = 1'b0;
        spi_done  = 1'b0;
    endtask

    task automatic check(input string name,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {9'b0, spi_wrt, spi_cmd, owner, busy, inert_done,
                inert_rd, a2d_done, a2d_rd, ovf_err, tmo_err};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("reset_outputs", outs(), 64'd0);
    endtask

    task automatic wait_wrt(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (spi_wrt) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_spi_wrt: no spi_wrt within %0d clks",
                     bound);
        end
    endtask

    initial begin
        bit ok;
        int k;
        logic exp_g[5];
        logic [52:0] act_v, exp_v;

        // iw ic aw ac sd sr | wrt cmd own busy idone ird adone ard
        tbl[0]  = '{1, 16'hA2C3, 0, 0, 0, 0,
                    0, 16'h0000, 0, 0, 0, 16'h0000, 0, 16'h0000};
        tbl[1]  = '{0, 0, 0, 0, 0, 0,
                    1, 16'hA2C3, 0, 1, 0, 16'h0000, 0, 16'h0000};
        tbl[2]  = '{0, 0, 0, 0, 1, 16'h1234,
                    0, 16'hA2C3, 0, 1, 1, 16'h1234, 0, 16'h0000};
        tbl[3]  = '{0, 0, 0, 0, 0, 0,
                    0, 16'hA2C3, 0, 1, 0, 16'h1234, 0, 16'h0000};
        tbl[4]  = '{1, 16'h1111, 1, 16'h2222, 0, 0,
                    0, 16'hA2C3, 0, 1, 0, 16'h1234, 0, 16'h0000};
        tbl[5]  = '{0, 0, 0, 0, 0, 0,
                    0, 16'hA2C3, 0, 1, 0, 16'h1234, 0, 16'h0000};
        tbl[6]  = '{0, 0, 0, 0, 0, 0,
                    0, 16'hA2C3, 0, 0, 0, 16'h1234, 0, 16'h0000};
        tbl[7]  = '{0, 0, 0, 0, 0, 0,
                    1, 16'h1111, 0, 1, 0, 16'h1234, 0, 16'h0000};
        tbl[8]  = '{0, 0, 0, 0, 1, 16'h5555,
                    0, 16'h1111, 0, 1, 1, 16'h5555, 0, 16'h0000};
        tbl[9]  = '{0, 0, 0, 0, 0, 0,
                    0, 16'h1111, 0, 1, 0, 16'h5555, 0, 16'h0000};
        tbl[10] = '{0, 0, 0, 0, 0, 0,
                    0, 16'h1111, 0, 1, 0, 16'h5555, 0, 16'h0000};
        tbl[11] = '{0, 0, 0, 0, 0, 0,
                    0, 16'h1111, 0, 1, 0, 16'h5555, 0, 16'h0000};
        tbl[12] = '{0, 0, 0, 0, 0, 0,
                    0, 16'h1111, 0, 0, 0, 16'h5555, 0, 16'h0000};
        tbl[13] = '{0, 0, 0, 0, 0, 0,
                    1, 16'h2222, 1, 1, 0, 16'h5555, 0, 16'h0000};
        tbl[14] = '{0, 0, 0, 0, 1, 16'hABCD,
                    0, 16'h2222, 1, 1, 0, 16'h5555, 1, 16'hABCD};
        tbl[15] = '{0, 0, 0, 0, 0, 0,
                    0, 16'h2222, 1, 1, 0, 16'h5555, 0, 16'hABCD};
        tbl[16] = '{0, 0, 0, 0, 1, 16'h0BAD,
                    0, 16'h2222, 1, 1, 0, 16'h5555, 0, 16'hABCD};

        // cycle table: single issue, then simultaneous posts across a gap
        do_reset();
        for (int i = 0; i < 17; i++) begin
            inert_wrt = tbl[i].iw;
            inert_cmd = tbl[i].ic;
            a2d_wrt   = tbl[i].aw;
            a2d_cmd   = tbl[i].ac;
            spi_done  = tbl[i].sd;
            spi_rd    = tbl[i].sr;
            tick();
            act_v = {spi_wrt, spi_cmd, owner, busy, inert_done,
                     inert_rd, a2d_done, a2d_rd};
            exp_v = {tbl[i].e_wrt, tbl[i].e_cmd, tbl[i].e_own,
                     tbl[i].e_busy, tbl[i].e_idone, tbl[i].e_ird,
                     tbl[i].e_adone, tbl[i].e_ard};
            check($sformatf("table_row%0d", i), act_v, exp_v);
        end

        // streak cap: I,I,I then A, then inertial again
        do_reset();
        exp_g = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        a2d_cmd   = 16'hA000;
        a2d_wrt   = 1'b1;
        inert_cmd = 16'h1000;
        inert_wrt = 1'b1;
        for (int g = 0; g < 5; g++) begin
            wait_wrt(20, ok);
            if (!ok) break;
            check($sformatf("streak_grant%0d", g), owner, exp_g[g]);
            if (owner) begin
                check("streak_a2d_cmd", spi_cmd, 16'hA000);
                a2d_cmd = 16'hA001;
                a2d_wrt = 1'b1;
            end else begin
                inert_cmd = 16'h1001 + 16'(g);
                inert_wrt = 1'b1;
            end
            tick();
            spi_done = 1'b1;
            spi_rd   = 16'(g);
            tick();
        end

        // overflow on a full, non-issuing A2D slot
        do_reset();
        inert_cmd = 16'h0001;
        inert_wrt = 1'b1;
        wait_wrt(10, ok);
        a2d_cmd = 16'h0AAA;
        a2d_wrt = 1'b1;
        tick();
        check("ovf_before", ovf_err, 1'b0);
        a2d_cmd = 16'h0BBB;
        a2d_wrt = 1'b1;
        tick();
        check("ovf_set", ovf_err, 1'b1);
        spi_done = 1'b1;
        tick();
        wait_wrt(12, ok);
        check("ovf_owner", owner, 1'b1);
        check("ovf_kept_cmd", spi_cmd, 16'h0AAA);
        spi_done = 1'b1;
        tick();
        do_reset();
        check("ovf_cleared", ovf_err, 1'b0);

        // timeout with spi_done withheld, stray done in gap
        inert_cmd = 16'hCCCC;
        inert_wrt = 1'b1;
        wait_wrt(10, ok);
        k = 0;
        while (!inert_done && k < TMO + 100) begin
            tick();
            k++;
        end
        check("tmo_latency", k, TMO);
        check("tmo_rd", inert_rd, 16'hFFFF);
        check("tmo_err", tmo_err, 1'b1);
        check("tmo_a2d_quiet", a2d_done, 1'b0);
        spi_done = 1'b1;
        spi_rd   = 16'h1357;
        tick();
        check("stray_done", {inert_done, a2d_done}, 2'b00);
        check("stray_rd", inert_rd, 16'hFFFF);
        for (int i = 0; i < 6; i++) tick();
        check("tmo_back_idle", busy, 1'b0);

        // reset in the middle of BUSY
        inert_cmd = 16'h6666;
        inert_wrt = 1'b1;
        wait_wrt(10, ok);
        tick();
        check("midbusy_busy", busy, 1'b1);
        rst = 1'b1;
        tick();
        check("midbusy_reset", outs(), 64'd0);
        rst = 1'b0;
        spi_done = 1'b1;
        spi_rd   = 16'h7777;
        tick();
        check("post_rst_done", {inert_done, a2d_done, inert_rd}, 18'd0);
        tick();
        check("post_rst_done2", {inert_done, a2d_done, busy}, 3'd0);

        // randomized traffic against a transaction-level model
        do_reset();
        m_has     = '{0, 0};
        m_edge    = '{0, 0};
        m_streak  = 0;
        last_done = -100;
        sp_active = 0;
        exp_done  = 0;
        grants    = 0;
        for (int t = 0; t < 4100; t++) begin
            tick();
            if (exp_done) begin
                check("rand_done", {inert_done, a2d_done},
                      (exp_own == 1) ? 2'b01 : 2'b10);
                check("rand_rd", (exp_own == 1) ? a2d_rd : inert_rd,
                      exp_data);
                exp_done  = 0;
                last_done = cyc;
            end else begin
                check("rand_no_done", {inert_done, a2d_done}, 2'b00);
            end
            if (sp_active) check("rand_cmd_stable", spi_cmd, sp_cmd);
            if (spi_wrt) begin
                bit el_i, el_a;
                int g;
                el_i = m_has[0] && m_edge[0] < cyc;
                el_a = m_has[1] && m_edge[1] < cyc;
                check("rand_overlap", sp_active, 1'b0);
                if (!el_i && !el_a) begin
                    check("rand_spurious_wrt", spi_wrt, 1'b0);
                end else begin
                    g = (el_a && (!el_i || m_streak == MAXI)) ? 1 : 0;
                    check("rand_owner", owner, g[0]);
                    check("rand_cmd", spi_cmd, m_cmd[g]);
                    check("rand_gap", (cyc - last_done) >= GAP + 1, 1'b1);
                    if (g == 1) m_streak = 0;
                    else if (el_a && m_streak < MAXI) m_streak++;
                    m_has[g]  = 0;
                    grants++;
                    sp_active = 1;
                    sp_wait   = $urandom_range(0, 6);
                    sp_own    = g;
                    sp_data   = 16'($urandom);
                    sp_cmd    = m_cmd[g];
                end
            end
            if (sp_active) begin
                if (sp_wait == 0) begin
                    spi_done  = 1'b1;
                    spi_rd    = sp_data;
                    sp_active = 0;
                    exp_done  = 1;
                    exp_own   = sp_own;
                    exp_data  = sp_data;
                end else begin
                    sp_wait--;
                end
            end else if ($urandom_range(0, 9) == 0) begin
                spi_done = 1'b1;
                spi_rd   = 16'($urandom);
            end
            if (t < 4000) begin
                if (!m_has[0] && $urandom_range(0, 3) == 0) begin
                    inert_cmd = 16'($urandom);
                    inert_wrt = 1'b1;
                    m_has[0]  = 1;
                    m_cmd[0]  = inert_cmd;
                    m_edge[0] = cyc + 1;
                end
                if (!m_has[1] && $urandom_range(0, 3) == 0) begin
                    a2d_cmd   = 16'($urandom);
                    a2d_wrt   = 1'b1;
                    m_has[1]  = 1;
                    m_cmd[1]  = a2d_cmd;
                    m_edge[1] = cyc + 1;
                end
            end
        end
        check("rand_drained", {m_has[0], m_has[1], exp_done}, 3'b000);
        check("rand_grants_seen", grants > 100, 1'b1);
        check("rand_no_ovf", ovf_err, 1'b0);
        check("rand_no_tmo", tmo_err, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
